board_scan: RTL and testbench

- Reads the 32-bit board image written by the datapath and scans it out, one row at a time, to an external row-multiplexed LED matrix.
- The matrix is driven through a shift-register chain, so each row goes out serially (sdata/sclk), followed by a latch pulse and a timed display dwell.
- A board snapshot is taken only at frame start, so a board update mid-frame never tears the image.
- Sits between the datapath's board output and the chip pins.

---
 rtl/tetris_pkg.sv | 21 ++
 rtl/board_scan_if.sv | 26 ++
 rtl/scan_shifter.sv | 75 +++++++
 rtl/board_scan.sv | 148 ++++++++++++++
 tb/tb_board_scan.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the board datapath and its display scanner:
// board width, scan FSM state encoding and the board bit-index convention.
package tetris_pkg;

  localparam int BOARD_W = 32;
  localparam int BOARD_IDX_W = $clog2(BOARD_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_DWELL
  } scan_state_t;

  // Row 0 is the top row; bit r*cols+c holds row r, column c.
  function automatic int board_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/board_scan_if.sv
// Board-to-display bus: board image and run control in, LED matrix
// shift-chain pins and frame status out.
interface board_scan_if;
  import tetris_pkg::*;

  logic               enable;
  logic [BOARD_W-1:0] board_in;
  logic               sdata;
  logic               sclk;
  logic               latch;
  logic               oe_n;
  logic               frame_start;
  logic               frame_done;
  logic               busy;

  modport master (
    output enable, board_in,
    input  sdata, sclk, latch, oe_n, frame_start, frame_done, busy
  );

  modport slave (
    input  enable, board_in,
    output sdata, sclk, latch, oe_n, frame_start, frame_done, busy
  );

endinterface

// File: rtl/scan_shifter.sv
// Serialises one WIDTH-bit word MSB first on sdata/sclk: each bit is CLK_DIV
// cycles with sclk low then CLK_DIV cycles high; done_o marks the final cycle.
module scan_shifter #(
  parameter int WIDTH   = 12,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  output logic             sdata_o,
  output logic             sclk_o,
  output logic             done_o
);

  localparam int PERIOD = 2 * CLK_DIV;
  localparam int PH_W   = $clog2(PERIOD);
  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [BIT_W-1:0] bit_q;
  logic [PH_W-1:0]  phase_q;
  logic             active_q;
  logic             sdata_q;
  logic             sclk_q;

  assign shreg_d = shreg_q << 1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      bit_q    <= '0;
      phase_q  <= '0;
      active_q <= 1'b0;
      sdata_q  <= 1'b0;
      sclk_q   <= 1'b0;
    end else if (load_i) begin
      shreg_q  <= word_i;
      bit_q    <= '0;
      phase_q  <= '0;
      active_q <= 1'b1;
      sdata_q  <= word_i[WIDTH-1];
      sclk_q   <= 1'b0;
    end else if (active_q) begin
      if (phase_q == PH_LAST) begin
        // sclk falls and sdata advances on the same edge, so sdata only moves while sclk is low.
        sclk_q  <= 1'b0;
        phase_q <= '0;
        if (bit_q == BIT_LAST) begin
          active_q <= 1'b0;
          sdata_q  <= 1'b0;
        end else begin
          bit_q   <= bit_q + 1'b1;
          shreg_q <= shreg_d;
          sdata_q <= shreg_d[WIDTH-1];
        end
      end else begin
        phase_q <= phase_q + 1'b1;
        if (phase_q == PH_RISE) sclk_q <= 1'b1;
      end
    end
  end

  assign sdata_o = sdata_q;
  assign sclk_o  = sclk_q;
  assign done_o  = active_q && (phase_q == PH_LAST) && (bit_q == BIT_LAST);

endmodule

// File: rtl/board_scan.sv
// Row-multiplexed LED matrix scanner: snapshots the board at frame start and
// shifts out one-hot row select plus column bits per row. Option: SCAN_BLANK_EN.
module board_scan
  import tetris_pkg::*;
#(
  parameter int ROWS    = 8,
  parameter int COLS    = 4,
  parameter int CLK_DIV = 2,
  parameter int DWELL   = 64
) (
  input  logic         clka,
  input  logic         restart,
  board_scan_if.slave  bus
);

  localparam int NBITS = ROWS + COLS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW_W  = $clog2(DWELL);

  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [DW_W-1:0]  DWELL_PRE  = DW_W'(DWELL - 2);
  localparam logic [DW_W-1:0]  BLANK_LAST = DW_W'(3);

`ifdef SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  scan_state_t        state_q;
  logic [BOARD_W-1:0] snap_q;
  logic [ROW_W-1:0]   row_q;
  logic [DW_W-1:0]    dwell_q;
  logic               latch_q;
  logic               oe_n_q;
  logic               frame_start_q;
  logic               frame_done_q;
  logic               busy_q;

  logic               row_end;
  logic               shift_load;
  logic               shift_done;
  logic [ROW_W-1:0]   word_row;
  logic [NBITS-1:0]   shift_word;

  function automatic logic [NBITS-1:0] row_word(input logic [ROW_W-1:0] r,
                                                input logic [BOARD_W-1:0] b);
    logic [ROWS-1:0]        sel;
    logic [BOARD_IDX_W-1:0] base;
    sel    = '0;
    sel[r] = 1'b1;
    base   = BOARD_IDX_W'(board_idx(int'(r), 0, COLS));
    return {sel, b[base +: COLS]};
  endfunction

  // The shifter is loaded on the edge that enters SHIFT, so its first bit
  // is already on sdata in the first SHIFT cycle.
  assign row_end    = (state_q == S_DWELL) && (dwell_q == DWELL_LAST);
  assign word_row   = (state_q == S_LOAD) ? '0 : row_q + 1'b1;
  assign shift_load = (state_q == S_LOAD) || (row_end && (row_q != ROW_LAST));
  assign shift_word = row_word(word_row, snap_q);

  scan_shifter #(
    .WIDTH   (NBITS),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clka),
    .rst_n   (restart),
    .load_i  (shift_load),
    .word_i  (shift_word),
    .sdata_o (bus.sdata),
    .sclk_o  (bus.sclk),
    .done_o  (shift_done)
  );

  // NOTE: the snapshot is an ordinary register bank, so it takes the async
  // reset like the rest of the state; there is no memory macro to exclude.
  always_ff @(posedge clka or negedge restart) begin
    if (!restart) begin
      state_q       <= S_IDLE;
      snap_q        <= '0;
      row_q         <= '0;
      dwell_q       <= '0;
      latch_q       <= 1'b0;
      oe_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      latch_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.enable) begin
            state_q       <= S_LOAD;
            snap_q        <= bus.board_in;
            row_q         <= '0;
            frame_start_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        S_LOAD:  state_q <= S_SHIFT;
        S_SHIFT: begin
          if (shift_done) begin
            state_q <= S_LATCH;
            latch_q <= 1'b1;
          end
        end
        S_LATCH: begin
          state_q <= S_DWELL;
          dwell_q <= '0;
          oe_n_q  <= BLANK;
        end
        S_DWELL: begin
          if (dwell_q == DWELL_LAST) begin
            oe_n_q <= 1'b1;
            if (row_q != ROW_LAST) begin
              row_q   <= row_q + 1'b1;
              state_q <= S_SHIFT;
            end else if (bus.enable) begin
              state_q       <= S_LOAD;
              snap_q        <= bus.board_in;
              row_q         <= '0;
              frame_start_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
            if ((dwell_q == DWELL_PRE) && (row_q == ROW_LAST)) frame_done_q <= 1'b1;
            if (BLANK && (dwell_q == BLANK_LAST)) oe_n_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.latch       = latch_q;
  assign bus.oe_n        = oe_n_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_board_scan.sv
// Bench for board_scan: decodes the shift chain back into row words and
// compares them, plus frame/row timing, against an arithmetic model.
module tb_board_scan;

  localparam int ROWS      = 8;
  localparam int COLS      = 4;
  localparam int CLK_DIV   = 2;
  localparam int DWELL     = 64;
  localparam int NBITS     = ROWS + COLS;
  localparam int SHIFT_CYC = 2 * CLK_DIV * NBITS;
  localparam int ROW_P     = SHIFT_CYC + 1 + DWELL;
  localparam int FRAME_P   = ROWS * ROW_P + 1;
`ifdef SCAN_BLANK_EN
  localparam int OE_LOW = DWELL - 4;
`else
  localparam int OE_LOW = DWELL;
`endif

  logic clka = 1'b0;
  logic restart;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  board_scan_if bus();

  board_scan #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .CLK_DIV (CLK_DIV),
    .DWELL   (DWELL)
  ) dut (
    .clka    (clka),
    .restart (restart),
    .bus     (bus)
  );

  always #5 clka = ~clka;
  always @(posedge clka) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clka);
  endtask

  // Row word as seen on the chain: one-hot row select above the column nibble.
  function automatic logic [31:0] exp_word(input int r, input logic [31:0] snap);
    return ((32'd1 << r) << COLS) | ((snap >> (r * COLS)) & ((32'd1 << COLS) - 1));
  endfunction

  task automatic wait_frame_start(input int budget, input int exp_delay);
    int k;
    bit seen;
    seen = 1'b0;
    for (k = 1; k <= budget; k++) begin
      tick();
      if (bus.frame_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_start_seen", 32'(seen), 32'd1);
    if (seen) check("frame_start_delay", k, exp_delay);
  endtask

  // Called in the LOAD-cycle sample; scans one full frame and its aftermath.
  task automatic scan_frame(input logic [31:0] snap, input int chg_row,
                            input logic [31:0] chg_val, input int drop_row);
    int          t0, prev_latch, acc_n, low_n, guard;
    logic [31:0] acc;
    logic        prev_sclk, held;
    t0 = cyc;
    check("load_busy", 32'(bus.busy), 32'd1);
    check("load_oe_n", 32'(bus.oe_n), 32'd1);
    check("load_frame_done", 32'(bus.frame_done), 32'd0);
    prev_latch = t0;
    for (int r = 0; r < ROWS; r++) begin
      if (r == chg_row) bus.board_in = chg_val;
      if (r == drop_row) bus.enable = 1'b0;
      acc = '0; acc_n = 0; prev_sclk = 1'b0; held = 1'b0; guard = 0;
      do begin
        tick();
        guard++;
        if (bus.sclk && !prev_sclk) begin
          acc   = {acc[30:0], bus.sdata};
          acc_n++;
          held  = bus.sdata;
        end else if (bus.sclk) begin
          check("sdata_stable_high", 32'(bus.sdata), 32'(held));
        end
        if (!bus.latch) check("shift_oe_n", 32'(bus.oe_n), 32'd1);
        prev_sclk = bus.sclk;
      end while (bus.latch !== 1'b1 && guard < 2 * ROW_P);
      check("latch_seen", 32'(bus.latch), 32'd1);
      check("latch_sclk", 32'(bus.sclk), 32'd0);
      check("row_bits", acc_n, NBITS);
      check($sformatf("row%0d_word", r), acc, exp_word(r, snap));
      check("latch_time", cyc - prev_latch, (r == 0) ? SHIFT_CYC + 1 : ROW_P);
      prev_latch = cyc;
      low_n = 0;
      for (int k = 0; k < DWELL; k++) begin
        tick();
        if (bus.oe_n === 1'b0) low_n++;
        check("dwell_latch", 32'(bus.latch), 32'd0);
        check("frame_done", 32'(bus.frame_done), 32'(r == ROWS - 1 && k == DWELL - 1));
      end
      check("oe_low_cycles", low_n, OE_LOW);
    end
    tick();
    check("no_done_after_end", 32'(bus.frame_done), 32'd0);
    if (bus.enable) begin
      check("next_frame_start", 32'(bus.frame_start), 32'd1);
      check("frame_period", cyc - t0, FRAME_P);
    end else begin
      for (int k = 0; k < 10; k++) begin
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_sclk", 32'(bus.sclk), 32'd0);
        check("idle_oe_n", 32'(bus.oe_n), 32'd1);
        check("idle_frame_start", 32'(bus.frame_start), 32'd0);
        tick();
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sdata"}, 32'(bus.sdata), 32'd0);
    check({tag, "_sclk"}, 32'(bus.sclk), 32'd0);
    check({tag, "_latch"}, 32'(bus.latch), 32'd0);
    check({tag, "_oe_n"}, 32'(bus.oe_n), 32'd1);
    check({tag, "_frame_start"}, 32'(bus.frame_start), 32'd0);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] r1, r2, r3, r4;
    r1 = $urandom; r2 = $urandom; r3 = $urandom; r4 = $urandom;
    restart      = 1'b0;
    bus.enable   = 1'b0;
    bus.board_in = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    restart = 1'b1;
    tick();
    check("idle_without_enable", 32'(bus.busy), 32'd0);

    // Single-nibble board, then checkerboard, then all ones; each frame
    // changes board_in mid-frame, which must not reach the current image.
    bus.board_in = 32'h0000_000F;
    bus.enable   = 1'b1;
    wait_frame_start(4, 1);
    scan_frame(32'h0000_000F, 3, 32'hA5A5_A5A5, -1);
    scan_frame(32'hA5A5_A5A5, 3, 32'hFFFF_FFFF, -1);
    scan_frame(32'hFFFF_FFFF, 1, r1, -1);
    // Random board, enable dropped at row 2: frame completes, then idle.
    scan_frame(r1, 5, r2, 2);

    // Reset in the high phase of row 5's select bit.
    bus.board_in = r3;
    bus.enable   = 1'b1;
    wait_frame_start(4, 1);
    repeat (1 + 5 * ROW_P + 10) tick();
    check("pre_reset_sclk", 32'(bus.sclk), 32'd1);
    check("pre_reset_sdata", 32'(bus.sdata), 32'd1);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2 restart = 1'b0;
    #1 check_reset_outputs("async_reset");
    tick();
    restart      = 1'b1;
    bus.board_in = r4;
    wait_frame_start(4, 1);
    scan_frame(r4, -1, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
